// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// instr_sequencer_if : instruction handshake and register-file/ALU bundle
// Revision: 1.0
// ----------------------------------------------------------------------
interface instr_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  ALUControl;
    logic [3:0]  readReg1;
    logic [3:0]  readReg2;
    logic [3:0]  writeReg;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        zero_flag;
    logic [15:0] retired_count;

    modport slave (
        input  instr_valid, instr, ALUResult, Zero,
        output instr_ready, ALUControl, readReg1, readReg2, writeReg,
               writeData, writeEnable, zero_flag, retired_count
    );

    modport master (
        output instr_valid, instr, ALUResult, Zero,
        input  instr_ready, ALUControl, readReg1, readReg2, writeReg,
               writeData, writeEnable, zero_flag, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// instr_sequencer : IDLE/DECODE/EXECUTE/WRITEBACK instruction sequencer.
//   Define INSTR_SEQUENCER_SKIPZ_EN to enable the SKIPZ (op 4'hE) feature.
// Revision: 1.0
// ----------------------------------------------------------------------
module instr_sequencer (
    input  wire logic        clk,
    input  wire logic        reset,
    instr_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_LOADI = 4'hF;
`ifdef INSTR_SEQUENCER_SKIPZ_EN
    localparam logic [3:0] c_OP_SKIPZ = 4'hE;
    logic        r_skip;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_instr;
    logic [3:0]  r_alu_ctrl;
    logic [3:0]  r_rd1;
    logic [3:0]  r_rd2;
    logic [3:0]  r_wr_reg;
    logic [31:0] r_wr_data;
    logic        r_wr_en;
    logic        r_zero_flag;
    logic [15:0] r_retired;
    logic [3:0]  w_op;
    logic [3:0]  w_rd;

    assign w_op = r_instr[15:12];
    assign w_rd = r_instr[11:8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.instr_valid) w_state_nxt = DECODE;
            end
            DECODE: begin
`ifdef INSTR_SEQUENCER_SKIPZ_EN
                if (r_skip || (w_op == c_OP_SKIPZ)) w_state_nxt = IDLE;
                else
`endif
                if (w_op == c_OP_LOADI) w_state_nxt = WRITEBACK;
                else                    w_state_nxt = EXECUTE;
            end
            EXECUTE:   w_state_nxt = WRITEBACK;
            WRITEBACK: w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // The write strobe is set on entry to WRITEBACK and dropped on the next edge,
    // so it is high exactly while the FSM sits in WRITEBACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_instr     <= 16'h0000;
            r_alu_ctrl  <= 4'h0;
            r_rd1       <= 4'h0;
            r_rd2       <= 4'h0;
            r_wr_reg    <= 4'h0;
            r_wr_data   <= 32'h0000_0000;
            r_wr_en     <= 1'b0;
            r_zero_flag <= 1'b0;
            r_retired   <= 16'h0000;
`ifdef INSTR_SEQUENCER_SKIPZ_EN
            r_skip      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.instr_valid) r_instr <= bus.instr;
                end
                DECODE: begin
`ifdef INSTR_SEQUENCER_SKIPZ_EN
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (w_op == c_OP_SKIPZ) begin
                        r_skip    <= r_zero_flag;
                        r_retired <= r_retired + 16'd1;
                    end else
`endif
                    if (w_op == c_OP_LOADI) begin
                        r_wr_reg  <= w_rd;
                        r_wr_data <= {24'h000000, r_instr[7:0]};
                        r_wr_en   <= (w_rd != 4'h0);
                    end else begin
                        r_alu_ctrl <= w_op;
                        r_rd1      <= r_instr[7:4];
                        r_rd2      <= r_instr[3:0];
                    end
                end
                EXECUTE: begin
                    r_wr_data   <= bus.ALUResult;
                    r_zero_flag <= bus.Zero;
                    r_wr_reg    <= w_rd;
                    r_wr_en     <= (w_rd != 4'h0);
                end
                WRITEBACK: begin
                    r_retired <= r_retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready   = (r_state == IDLE);
    assign bus.ALUControl    = r_alu_ctrl;
    assign bus.readReg1      = r_rd1;
    assign bus.readReg2      = r_rd2;
    assign bus.writeReg      = r_wr_reg;
    assign bus.writeData     = r_wr_data;
    assign bus.writeEnable   = r_wr_en;
    assign bus.zero_flag     = r_zero_flag;
    assign bus.retired_count = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_instr_sequencer : randomized + directed bench with a cycle-level
//   timeline model of the sequencer and a simple register-file/ALU datapath.
// Revision: 1.0
// ----------------------------------------------------------------------
module tb_instr_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[4:0];
            4'h6:    return a >> b[4:0];
            default: return a + b + {28'h0, op};
        endcase
    endfunction

    // Datapath environment: register file cleared by reset, ALU combinational.
    logic [31:0] rf [16];
    always_comb begin
        bus.ALUResult = alu_f(bus.ALUControl, rf[bus.readReg1], rf[bus.readReg2]);
        bus.Zero      = (bus.ALUResult == 32'h0);
    end
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'h0;
        end else if (bus.writeEnable && bus.writeReg != 4'h0) begin
            rf[bus.writeReg] <= bus.writeData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Timeline model: each accepted instruction schedules its visible effects
    // at fixed sample offsets from the acceptance sample.
    logic [31:0] mrf [16];
    logic [3:0]  m_alu, m_r1, m_r2, m_wreg;
    logic [31:0] m_wdata;
    logic        m_we, m_zf, m_ready, m_skip;
    logic [15:0] m_ret;
    int          p_dec_t, p_zf_t, p_we_t, p_ret_t, next_free;
    logic [3:0]  p_alu, p_r1, p_r2, p_wreg;
    logic [31:0] p_wdata;
    logic        p_zf;

    initial begin
        logic [3:0]  op, rd, rs1, rs2;
        logic [31:0] res;
        logic [15:0] ins;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 16; i++) mrf[i] = 32'h0;
                m_alu = 0; m_r1 = 0; m_r2 = 0; m_wreg = 0; m_wdata = 0;
                m_we = 0; m_zf = 0; m_ret = 0; m_skip = 0; m_ready = 1'b1;
                p_dec_t = -1; p_zf_t = -1; p_we_t = -1; p_ret_t = -1; next_free = 0;
            end else begin
                m_we = 1'b0;
                if (cyc == p_dec_t) begin m_alu = p_alu; m_r1 = p_r1; m_r2 = p_r2; end
                if (cyc == p_zf_t) m_zf = p_zf;
                if (cyc == p_we_t) begin
                    m_we = (p_wreg != 4'h0); m_wreg = p_wreg; m_wdata = p_wdata;
                    if (p_wreg != 4'h0) mrf[p_wreg] = p_wdata;
                end
                if (cyc == p_ret_t) m_ret = m_ret + 16'd1;
                m_ready = (cyc >= next_free);
            end
            chk("instr_ready",   {31'h0, bus.instr_ready}, {31'h0, m_ready});
            chk("writeEnable",   {31'h0, bus.writeEnable}, {31'h0, m_we});
            chk("writeReg",      {28'h0, bus.writeReg},    {28'h0, m_wreg});
            chk("writeData",     bus.writeData,            m_wdata);
            chk("ALUControl",    {28'h0, bus.ALUControl},  {28'h0, m_alu});
            chk("readReg1",      {28'h0, bus.readReg1},    {28'h0, m_r1});
            chk("readReg2",      {28'h0, bus.readReg2},    {28'h0, m_r2});
            chk("zero_flag",     {31'h0, bus.zero_flag},   {31'h0, m_zf});
            chk("retired_count", {16'h0, bus.retired_count}, {16'h0, m_ret});
            if (reset && m_ready && bus.instr_valid) begin
                ins = bus.instr;
                op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
`ifdef INSTR_SEQUENCER_SKIPZ_EN
                if (m_skip) begin
                    m_skip = 1'b0; next_free = cyc + 2;
                end else if (op == 4'hE) begin
                    m_skip = m_zf; p_ret_t = cyc + 2; next_free = cyc + 2;
                end else
`endif
                if (op == 4'hF) begin
                    p_we_t = cyc + 2; p_wreg = rd; p_wdata = {24'h0, ins[7:0]};
                    p_ret_t = cyc + 3; next_free = cyc + 3;
                end else begin
                    res = alu_f(op, mrf[rs1], mrf[rs2]);
                    p_dec_t = cyc + 2; p_alu = op; p_r1 = rs1; p_r2 = rs2;
                    p_zf_t = cyc + 3; p_zf = (res == 32'h0);
                    p_we_t = cyc + 3; p_wreg = rd; p_wdata = res;
                    p_ret_t = cyc + 4; next_free = cyc + 4;
                end
            end
            cyc++;
        end
    end

    task automatic wait_accept(input logic [15:0] ins, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b1; bus.instr = ins;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.instr_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    // Offset of the writeEnable sample counted from the acceptance sample.
    task automatic run_instr(input logic [15:0] ins, output int we_off,
                             output logic [3:0] wr, output logic [31:0] wd);
        bit ok;
        we_off = -1; wr = 0; wd = 0;
        wait_accept(ins, ok);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.writeEnable && we_off < 0) begin
                we_off = k; wr = bus.writeReg; wd = bus.writeData;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int          off, acc, last;
        bit          sp_ok, ok, seen;
        logic [3:0]  wr;
        logic [31:0] wd, rnd;
        logic [3:0]  rop;
        checks = 0; failures = 0;
        reset = 1'b0; bus.instr_valid = 1'b0; bus.instr = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'h0, bus.instr_ready}, 32'h1);
        chk("reset_retired", {16'h0, bus.retired_count}, 32'h0);

        run_instr(16'hF110, off, wr, wd);
        chk("loadi_latency", off, 32'd2);
        chk("loadi_wreg", {28'h0, wr}, 32'h1);
        chk("loadi_wdata", wd, 32'h10);
        chk("loadi_retired", {16'h0, bus.retired_count}, 32'h1);

        run_instr(16'h0210, off, wr, wd);
        chk("add_latency", off, 32'd3);
        chk("add_wdata", wd, 32'h10);
        chk("add_readReg1", {28'h0, bus.readReg1}, 32'h1);
        chk("add_readReg2", {28'h0, bus.readReg2}, 32'h0);
        chk("add_zero_flag", {31'h0, bus.zero_flag}, 32'h0);

        @(posedge clk); #1;
        bus.instr_valid = 1'b1; bus.instr = 16'h1311;
        acc = 0; last = -1; sp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                if (last >= 0 && (i - last) != 4) sp_ok = 1'b0;
                last = i; acc++;
            end
        end
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("hold_accepts", acc, 32'd3);
        chk("hold_spacing", {31'h0, sp_ok}, 32'h1);
        chk("sub_wdata", bus.writeData, 32'h0);
        chk("sub_zero_flag", {31'h0, bus.zero_flag}, 32'h1);

        run_instr(16'hF0FF, off, wr, wd);
        chk("rd0_no_write", off, -32'sd1);
        chk("rd0_retired", {16'h0, bus.retired_count}, 32'd6);

        // Abort an ALU instruction while it sits in EXECUTE.
        wait_accept(16'h0512, ok);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_we", {31'h0, bus.writeEnable}, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'h0, bus.instr_ready}, 32'h1);
        chk("abort_retired", {16'h0, bus.retired_count}, 32'h0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.writeEnable) seen = 1'b1; end
        chk("abort_no_late_we", {31'h0, seen}, 32'h0);

`ifdef INSTR_SEQUENCER_SKIPZ_EN
        run_instr(16'h1311, off, wr, wd);
        chk("skipz_pre_zf", {31'h0, bus.zero_flag}, 32'h1);
        run_instr(16'hE000, off, wr, wd);
        chk("skipz_no_write", off, -32'sd1);
        chk("skipz_retired", {16'h0, bus.retired_count}, 32'd2);
        run_instr(16'hF433, off, wr, wd);
        chk("skipped_no_write", off, -32'sd1);
        chk("skipped_retired", {16'h0, bus.retired_count}, 32'd2);
        run_instr(16'hF405, off, wr, wd);
        chk("after_skip_wreg", {28'h0, wr}, 32'h4);
        chk("after_skip_wdata", wd, 32'h5);
`endif

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rnd = $urandom;
            rop = ($urandom_range(0, 9) < 3) ? 4'hF : 4'($urandom_range(0, 14));
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr = {rop, rnd[11:0]};
        end
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
